instr_fetch_sequencer: RTL and testbench

Fetch controller that sequences the byte-addressable instruction memory (1024 x 8, asynchronous read). It walks the PC, issues one byte address per cycle, and assembles four bytes little-endian into a 32-bit word. It presents each word to decode with a valid/ready handshake. It accepts branch/jump redirects and traps misaligned targets.

---
 rtl/instr_fetch_sequencer_if.sv | 21 ++
 rtl/instr_fetch_sequencer.sv | 95 +++++++++
 tb/tb_instr_fetch_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// instr_fetch_sequencer_if: memory, decode and redirect signals of the fetch sequencer
interface instr_fetch_sequencer_if #(parameter int ADDR_WIDTH = 10);
   logic                  run;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_rdata;
   logic [31:0]           instr;
   logic [31:0]           instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  redirect_valid;
   logic [31:0]           redirect_pc;
   logic                  fault;
   modport master (
      input  run, mem_rdata, instr_ready, redirect_valid, redirect_pc,
      output mem_addr, instr, instr_pc, instr_valid, fault
   );
   modport slave (
      output run, mem_rdata, instr_ready, redirect_valid, redirect_pc,
      input  mem_addr, instr, instr_pc, instr_valid, fault
   );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: byte-serial instruction fetch, little-endian word assembly, redirect/misalign trap
module instr_fetch_sequencer #(
   parameter int ADDR_WIDTH = 10,
   parameter int RESET_PC   = 0
) (
   input logic                     clk,
   input logic                     reset_n,
   instr_fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;
   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n;
   logic [1:0]            byte_cnt, byte_cnt_n;
   logic [23:0]           byte_buf, byte_buf_n;
   logic [31:0]           instr, instr_n, instr_pc, instr_pc_n;
   logic                  instr_valid, instr_valid_n, fault, fault_n;
   logic                  unused_redirect_hi;
   assign unused_redirect_hi = ^bus.redirect_pc[31:ADDR_WIDTH];
   assign bus.mem_addr    = (state == FETCH) ? pc + ADDR_WIDTH'(byte_cnt) : pc;
   assign bus.instr       = instr;
   assign bus.instr_pc    = instr_pc;
   assign bus.instr_valid = instr_valid;
   assign bus.fault       = fault;
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      byte_cnt_n    = byte_cnt;
      byte_buf_n    = byte_buf;
      instr_n       = instr;
      instr_pc_n    = instr_pc;
      instr_valid_n = instr_valid;
      fault_n       = fault;
      // a redirect outranks fetch/hold; in HOLD it also retires or drops the held word
      if (state != FAULT && bus.redirect_valid) begin
         instr_valid_n = 1'b0;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            state_n = FAULT;
            fault_n = 1'b1;
         end else begin
            state_n    = bus.run ? FETCH : IDLE;
            pc_n       = bus.redirect_pc[ADDR_WIDTH-1:0];
            byte_cnt_n = 2'd0;
            byte_buf_n = '0;
         end
      end else begin
         case (state)
            IDLE: begin
               state_n    = bus.run ? FETCH : IDLE;
               byte_cnt_n = 2'd0;
            end
            FETCH: begin
               if (byte_cnt == 2'd3) begin
                  instr_n       = {bus.mem_rdata, byte_buf};
                  instr_pc_n    = 32'(pc);
                  pc_n          = pc + ADDR_WIDTH'(4);
                  byte_cnt_n    = 2'd0;
                  instr_valid_n = 1'b1;
                  state_n       = HOLD;
               end else begin
                  byte_buf_n[{byte_cnt, 3'b000} +: 8] = bus.mem_rdata;
                  byte_cnt_n = byte_cnt + 2'd1;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  instr_valid_n = 1'b0;
                  state_n       = bus.run ? FETCH : IDLE;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= ADDR_WIDTH'(RESET_PC);
         byte_cnt    <= 2'd0;
         byte_buf    <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         byte_cnt    <= byte_cnt_n;
         byte_buf    <= byte_buf_n;
         instr       <= instr_n;
         instr_pc    <= instr_pc_n;
         instr_valid <= instr_valid_n;
         fault       <= fault_n;
      end
   end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed scoreboard bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;
   typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
   logic       clk = 1'b0;
   logic       reset_n0, reset_n1;
   logic [7:0] mem [1024];
   exp_t       sbq [$];
   int         ncmp = 0;
   int         nmis = 0;
   instr_fetch_sequencer_if #(.ADDR_WIDTH(10)) bus0 ();
   instr_fetch_sequencer_if #(.ADDR_WIDTH(10)) bus1 ();
   instr_fetch_sequencer #(.ADDR_WIDTH(10), .RESET_PC(0)) dut0 (
      .clk(clk), .reset_n(reset_n0), .bus(bus0)
   );
   instr_fetch_sequencer #(.ADDR_WIDTH(10), .RESET_PC(1020)) dut1 (
      .clk(clk), .reset_n(reset_n1), .bus(bus1)
   );
   assign bus0.mem_rdata = mem[bus0.mem_addr];
   assign bus1.mem_rdata = mem[bus1.mem_addr];
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic pop_check(input string tag, input logic [31:0] obs_instr, input logic [31:0] obs_pc);
      exp_t e;
      if (sbq.size() == 0) begin
         ncmp++;
         nmis++;
         $error("FAIL %s: observed word %h with empty scoreboard expected none", tag, obs_instr);
      end else begin
         e = sbq.pop_front();
         check({tag, "_instr"}, obs_instr, e.instr);
         check({tag, "_pc"}, obs_pc, e.pc);
      end
   endtask
   task automatic fetch_word0(input string tag, input logic [9:0] base);
      for (int k = 0; k < 4; k++) begin
         check({tag, "_addr"}, 32'(bus0.mem_addr), 32'(base + 10'(k)));
         check({tag, "_busy"}, 32'(bus0.instr_valid), 32'd0);
         tick();
      end
      check({tag, "_valid"}, 32'(bus0.instr_valid), 32'd1);
      pop_check(tag, bus0.instr, bus0.instr_pc);
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
      {mem[3], mem[2], mem[1], mem[0]} = 32'h00011020;
      {mem[7], mem[6], mem[5], mem[4]} = 32'h00421022;
      {mem[39], mem[38], mem[37], mem[36]} = 32'h14410008;
      {mem[1023], mem[1022], mem[1021], mem[1020]} = 32'h12345678;
      reset_n0 = 1'b0;
      reset_n1 = 1'b0;
      bus0.run = 1'b0; bus0.instr_ready = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
      bus1.run = 1'b0; bus1.instr_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
      tick();
      tick();
      check("rst_valid", 32'(bus0.instr_valid), 32'd0);
      check("rst_fault", 32'(bus0.fault), 32'd0);
      check("rst_instr", bus0.instr, 32'd0);
      check("rst_pc", bus0.instr_pc, 32'd0);
      check("rst_addr", 32'(bus0.mem_addr), 32'd0);
      // back-to-back words with ready tied high
      reset_n0 = 1'b1;
      bus0.run = 1'b1;
      bus0.instr_ready = 1'b1;
      sbq.push_back('{32'h00011020, 32'h0});
      sbq.push_back('{32'h00421022, 32'h4});
      tick();
      fetch_word0("w0", 10'd0);
      tick();
      fetch_word0("w1", 10'd4);
      // decode stalls for six cycles
      bus0.instr_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("stall_valid", 32'(bus0.instr_valid), 32'd1);
         check("stall_instr", bus0.instr, 32'h00421022);
         check("stall_pc", bus0.instr_pc, 32'h4);
         check("stall_addr", 32'(bus0.mem_addr), 32'h8);
      end
      bus0.instr_ready = 1'b1;
      tick();
      check("resume_valid", 32'(bus0.instr_valid), 32'd0);
      check("resume_addr", 32'(bus0.mem_addr), 32'h8);
      tick();
      tick();
      check("pre_redir_addr", 32'(bus0.mem_addr), 32'hA);
      // aligned redirect with two bytes of the old word already gathered
      bus0.redirect_valid = 1'b1;
      bus0.redirect_pc = 32'hFFFF_F024;
      tick();
      bus0.redirect_valid = 1'b0;
      sbq.push_back('{32'h14410008, 32'h24});
      fetch_word0("redir", 10'h24);
      // misaligned redirect while holding, ready high
      bus0.redirect_valid = 1'b1;
      bus0.redirect_pc = 32'h26;
      tick();
      check("fault_set", 32'(bus0.fault), 32'd1);
      check("fault_valid", 32'(bus0.instr_valid), 32'd0);
      check("fault_addr", 32'(bus0.mem_addr), 32'h28);
      bus0.redirect_pc = 32'h40;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("fault_sticky", 32'(bus0.fault), 32'd1);
         check("fault_novalid", 32'(bus0.instr_valid), 32'd0);
         check("fault_addr_hold", 32'(bus0.mem_addr), 32'h28);
      end
      bus0.redirect_valid = 1'b0;
      bus0.run = 1'b0;
      reset_n0 = 1'b0;
      tick();
      check("fault_clr", 32'(bus0.fault), 32'd0);
      check("fault_clr_addr", 32'(bus0.mem_addr), 32'd0);
      reset_n0 = 1'b1;
      tick();
      tick();
      check("idle_valid", 32'(bus0.instr_valid), 32'd0);
      check("idle_addr", 32'(bus0.mem_addr), 32'd0);
      // reset mid-fetch drops partial bytes
      bus0.run = 1'b1;
      tick();
      tick();
      tick();
      check("midfetch_addr", 32'(bus0.mem_addr), 32'd2);
      reset_n0 = 1'b0;
      tick();
      check("mfrst_addr", 32'(bus0.mem_addr), 32'd0);
      check("mfrst_valid", 32'(bus0.instr_valid), 32'd0);
      reset_n0 = 1'b1;
      sbq.push_back('{32'h00011020, 32'h0});
      tick();
      fetch_word0("mfrst_w", 10'd0);
      // reset during HOLD with ready high: no handshake, outputs cleared
      reset_n0 = 1'b0;
      tick();
      check("hrst_valid", 32'(bus0.instr_valid), 32'd0);
      check("hrst_instr", bus0.instr, 32'd0);
      check("hrst_pc", bus0.instr_pc, 32'd0);
      check("hrst_addr", 32'(bus0.mem_addr), 32'd0);
      // run dropped after the fetch starts still delivers the word
      reset_n0 = 1'b1;
      sbq.push_back('{32'h00011020, 32'h0});
      tick();
      bus0.run = 1'b0;
      fetch_word0("runoff_w", 10'd0);
      tick();
      check("runoff_valid", 32'(bus0.instr_valid), 32'd0);
      tick();
      check("runoff_idle_addr", 32'(bus0.mem_addr), 32'd4);
      // RESET_PC near the top of memory wraps to zero
      check("wrap_rst_addr", 32'(bus1.mem_addr), 32'd1020);
      reset_n1 = 1'b1;
      bus1.run = 1'b1;
      bus1.instr_ready = 1'b1;
      sbq.push_back('{32'h12345678, 32'd1020});
      sbq.push_back('{32'h00011020, 32'd0});
      tick();
      for (int k = 0; k < 4; k++) begin
         check("wrap_addr", 32'(bus1.mem_addr), 32'(1020 + k));
         tick();
      end
      check("wrap_valid", 32'(bus1.instr_valid), 32'd1);
      pop_check("wrap_w0", bus1.instr, bus1.instr_pc);
      check("wrap_hold_addr", 32'(bus1.mem_addr), 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("wrap_addr2", 32'(bus1.mem_addr), 32'(k));
         tick();
      end
      check("wrap_valid2", 32'(bus1.instr_valid), 32'd1);
      pop_check("wrap_w1", bus1.instr, bus1.instr_pc);
      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end
endmodule
